uart_fifo_core: RTL and testbench
=================================

// Module: uart_fifo_core
// PURPOSE
//  Parametrised full-duplex UART for the CPU peripheral bus; successor to the fixed 8N1 UART.
//  Single clock domain: internal 16x-oversample tick generator replaces separate baud/sample clocks.
//  Adds configurable data bits, parity and stop bits, TX/RX FIFOs, and sticky error flags.
//  CPU side is a simple push/pop interface; line side drives the PC serial pins.
// PARAMETERS
//  DIV        651  sysclk cycles per 16x tick (100 MHz / (9600*16)); legal >= 2
//  DATA_BITS  8    payload bits per frame, 5..8, sent LSB first
//  PARITY     0    0 = none, 1 = odd, 2 = even
//  STOP_BITS  1    1 or 2 stop bits (TX sends N; RX checks only the first)
//  FIFO_AW    4    FIFO address width; depth = 2**FIFO_AW per direction
// PORTS
//  sysclk       in   1          system clock, all logic on rising edge
//  reset        in   1          synchronous, active-high
//  PC_Uart_rxd  in   1          serial input, asynchronous, idle high
//  PC_Uart_txd  out  1          serial output, idle high
//  tx_data      in   DATA_BITS  byte to transmit
//  tx_wr        in   1          push tx_data into TX FIFO this cycle
//  tx_full      out  1          TX FIFO full; push ignored, tx_ovf set
//  tx_idle      out  1          TX FIFO empty and transmitter in IDLE
//  rx_data      out  DATA_BITS  head of RX FIFO (first-word fall-through)
//  rx_rd        in   1          pop RX FIFO head this cycle
//  rx_empty     out  1          RX FIFO empty; rx_data invalid, pop ignored
//  err_clr      in   1          clears all sticky error flags
//  err_flags    out  4          sticky {tx_ovf, rx_ovr, frame_err, parity_err}
// BEHAVIOUR
//  Reset: txd=1, tx_full=0, tx_idle=1, rx_empty=1, rx_data=0, err_flags=0; FIFOs, counters, FSMs cleared.
//  Reset mid-frame: txd high on the cycle after reset asserts; partial RX frame discarded.
//  Tick: counter 0..DIV-1, one-cycle tick at DIV-1; free-running after reset.
//  RX sync: 2-flop synchronizer on rxd; FSM acts on synchronized value (2-cycle input latency).
//  RX FSM IDLE->START on sync rxd==0 sampled on a tick; START: at tick 8 recheck, 1 -> IDLE (glitch), 0 -> DATA.
//  RX DATA: sample every 16 ticks (mid-bit), shift DATA_BITS bits; -> PARITY if PARITY!=0 else STOP.
//  RX PARITY: mismatch sets parity_err. RX STOP: sample 0 sets frame_err, byte still pushed.
//  RX push: on STOP sample; if RX FIFO full byte dropped, rx_ovr set; FSM -> IDLE, waits for line high before next start.
//  TX FSM IDLE->START when FIFO non-empty and tick; pops head into shift reg same cycle.
//  TX bit period 16 ticks each: START(0), DATA LSB first, PARITY (odd/even over data), STOP x STOP_BITS (1).
//  Back-to-back: next frame starts on first tick after last stop bit if FIFO non-empty.
//  FIFOs: pointers FIFO_AW+1 bits, wrap mod 2**(FIFO_AW+1); full = MSBs differ, low bits equal.
//  Simultaneous push+pop: on empty FIFO only push takes effect; on full, pop then push both succeed (count unchanged).
//  rx_data updates the cycle after a pop or a push into an empty FIFO.
//  err_clr has priority over a same-cycle error set? No: a same-cycle new error wins (flag stays 1).
//  tx_wr while tx_full: data discarded, tx_ovf set; FIFO contents unchanged.
// TESTING (bench uses DIV=4 -> 64 cycles/bit)
//  1. 8N1, push 0xA5 -> txd: 0 then 1,0,1,0,0,1,0,1 then 1, each 64 cycles; tx_idle=1 after stop.
//  2. Loopback txd->rxd, push 0x00,0xFF,0x3C -> rx pops 0x00,0xFF,0x3C, err_flags=0.
//  3. PARITY=2, inject frame 0x07 with parity bit 0 -> rx_data=0x07, err_flags=4'b0001.
//  4. Stop bit forced 0 -> frame_err=1, byte pushed; err_clr pulse -> err_flags=0.
//  5. FIFO_AW=2, receive 5 frames without popping -> 4 stored in order, rx_ovr=1; 17 pushes to TX (AW=4) -> tx_ovf=1.
//  6. reset asserted mid-data-bit of TX -> txd=1 next cycle, tx_idle=1, FIFOs empty; 1-tick rxd low glitch -> no push.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: parametrised full-duplex UART with 16x-oversampled receiver,
// TX/RX FIFOs and sticky error flags, all in the sysclk domain.
// Ports:
//   sysclk, reset          clock and synchronous active-high reset
//   PC_Uart_rxd/txd        serial line in (asynchronous) / out, both idle high
//   tx_data, tx_wr         push a byte into the TX FIFO
//   tx_full, tx_idle       TX FIFO full / nothing queued and transmitter idle
//   rx_data, rx_rd         RX FIFO head (first-word fall-through) and pop
//   rx_empty               RX FIFO empty
//   err_clr, err_flags     clear / sticky {tx_ovf, rx_ovr, frame_err, parity_err}
module uart_fifo_core #(
    parameter int unsigned DIV       = 651,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 PC_Uart_rxd,
    output logic                 PC_Uart_txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic                 tx_idle,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_rd,
    output logic                 rx_empty,
    input  logic                 err_clr,
    output logic [3:0]           err_flags
);
    localparam int unsigned TW    = $clog2(DIV);
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic                 rxd_s1_q, rxd_s2_q;
    logic [2:0]           rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d, rx_bit_q, rx_bit_d;
    logic [3:0]           tx_tcnt_q, tx_tcnt_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic                 tx_stop_q, tx_stop_d, tx_par_q, tx_par_d, txd_q, txd_d;
    logic [DATA_BITS-1:0] tx_mem_q [DEPTH];
    logic [DATA_BITS-1:0] rx_mem_q [DEPTH];
    logic [PW-1:0]        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0]        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d, tx_head;
    logic [3:0]           err_q, err_d;
    logic                 tx_empty, rx_full, tx_pop, tx_load, tx_push_ok;
    logic                 rx_push, rx_pop, rx_push_ok, rx_mid, tx_end, set_par, set_frame;

    assign tick     = (tick_cnt_q == TW'(DIV - 1));
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                      (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                      (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
    assign tx_head  = tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
    assign rx_mid   = tick && (rx_tcnt_q == 4'd15);
    assign tx_end   = tick && (tx_tcnt_q == 4'd15);

    assign PC_Uart_txd = txd_q;
    assign tx_idle     = tx_empty && (tx_state_q == S_IDLE);
    assign rx_data     = rx_data_q;
    assign err_flags   = err_q;

    // Next-state logic for tick generator, receiver, transmitter, FIFOs and flags
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        if (tick && (rx_state_q == S_DATA || rx_state_q == S_PAR || rx_state_q == S_STOP))
            rx_tcnt_d = rx_tcnt_q + 4'd1;
        case (rx_state_q)
            S_IDLE: if (tick && !rxd_s2_q) begin
                rx_state_d = S_START;
                rx_tcnt_d  = '0;
            end
            // Recheck half a bit later so a short low glitch is not taken as a start
            S_START: if (tick) begin
                if (rx_tcnt_q == 4'd7) begin
                    rx_tcnt_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                end
            end
            S_DATA: if (rx_mid) begin
                rx_shift_d = {rxd_s2_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
                if (rx_bit_q == 4'(DATA_BITS - 1))
                    rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: if (rx_mid) begin
                set_par    = rxd_s2_q != ((PARITY == 1) ? ~(^rx_shift_q) : ^rx_shift_q);
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_mid) begin
                rx_push    = 1'b1;
                set_frame  = !rxd_s2_q;
                rx_state_d = S_WAIT;
            end
            // A low stop bit must not be mistaken for the next start bit
            S_WAIT:  if (rxd_s2_q) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase

        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_stop_d  = tx_stop_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        if (tick && tx_state_q != S_IDLE) tx_tcnt_d = tx_tcnt_q + 4'd1;
        case (tx_state_q)
            S_IDLE:  tx_load = tick && !tx_empty;
            S_START: if (tx_end) begin
                tx_state_d = S_DATA;
                txd_d      = tx_shift_q[0];
                tx_bit_d   = '0;
            end
            S_DATA: if (tx_end) begin
                if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                    if (PARITY != 0) begin
                        tx_state_d = S_PAR;
                        txd_d      = tx_par_q;
                    end else begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                        tx_stop_d  = 1'b0;
                    end
                end else begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    txd_d      = tx_shift_q[1];
                end
            end
            S_PAR: if (tx_end) begin
                tx_state_d = S_STOP;
                txd_d      = 1'b1;
                tx_stop_d  = 1'b0;
            end
            // Last stop bit ends on a tick, so a queued byte starts immediately
            S_STOP: if (tx_end) begin
                if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                    if (!tx_empty) tx_load = 1'b1;
                    else           tx_state_d = S_IDLE;
                end else begin
                    tx_stop_d = 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_shift_d = tx_head;
            tx_par_d   = (PARITY == 1) ? ~(^tx_head) : ^tx_head;
            txd_d      = 1'b0;
            tx_tcnt_d  = '0;
        end

        // A push on a full FIFO succeeds only when the head leaves the same cycle
        tx_push_ok = tx_wr && (!tx_full || tx_pop);
        tx_wp_d    = tx_wp_q + PW'(tx_push_ok);
        tx_rp_d    = tx_rp_q + PW'(tx_pop);
        rx_pop     = rx_rd && !rx_empty;
        rx_push_ok = rx_push && (!rx_full || rx_pop);
        rx_wp_d    = rx_wp_q + PW'(rx_push_ok);
        rx_rp_d    = rx_rp_q + PW'(rx_pop);

        // Registered head: bypass the memory when the new head is being written now
        rx_data_d = rx_data_q;
        if (rx_wp_d != rx_rp_d) begin
            if (rx_push_ok && (rx_rp_d == rx_wp_q)) rx_data_d = rx_shift_q;
            else                                    rx_data_d = rx_mem_q[rx_rp_d[FIFO_AW-1:0]];
        end

        err_d = (err_clr ? 4'b0000 : err_q) |
                {tx_wr && !tx_push_ok, rx_push && !rx_push_ok, set_frame, set_par};
    end

    // State registers
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_stop_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_data_q  <= '0;
            err_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            rxd_s1_q   <= PC_Uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_stop_q  <= tx_stop_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge sysclk) begin
        if (tx_push_ok) tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= tx_data;
        if (rx_push_ok) rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= rx_shift_q;
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: self-checking bench for uart_fifo_core.
// dut_a: 8N1, 16-deep FIFOs, optional txd->rxd loopback.
// dut_p: 8E2, 4-deep FIFOs, receive side driven directly by the bench.
module tb_uart_fifo_core;
    localparam int BIT_CYC = 64;

    logic       clk, reset, loop_en;
    logic       rxd_drv_a, rxd_a, txd_a, tx_wr_a, tx_full_a, tx_idle_a, rx_rd_a, rx_empty_a, err_clr_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic [3:0] err_a;
    logic       rxd_drv_p, txd_p, tx_wr_p, tx_full_p, tx_idle_p, rx_rd_p, rx_empty_p, err_clr_p;
    logic [7:0] tx_data_p, rx_data_p;
    logic [3:0] err_p;
    int         errors = 0;
    int         checks = 0;

    assign rxd_a = loop_en ? txd_a : rxd_drv_a;

    uart_fifo_core #(.DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)) dut_a (
        .sysclk(clk), .reset(reset), .PC_Uart_rxd(rxd_a), .PC_Uart_txd(txd_a),
        .tx_data(tx_data_a), .tx_wr(tx_wr_a), .tx_full(tx_full_a), .tx_idle(tx_idle_a),
        .rx_data(rx_data_a), .rx_rd(rx_rd_a), .rx_empty(rx_empty_a),
        .err_clr(err_clr_a), .err_flags(err_a));

    uart_fifo_core #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_AW(2)) dut_p (
        .sysclk(clk), .reset(reset), .PC_Uart_rxd(rxd_drv_p), .PC_Uart_txd(txd_p),
        .tx_data(tx_data_p), .tx_wr(tx_wr_p), .tx_full(tx_full_p), .tx_idle(tx_idle_p),
        .rx_data(rx_data_p), .rx_rd(rx_rd_p), .rx_empty(rx_empty_p),
        .err_clr(err_clr_p), .err_flags(err_p));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Advance n cycles; stimulus and sampling both happen 1 time unit after the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one serial frame (start, 8 data LSB first, parity for dut_p, stop, idle)
    task automatic send_frame(input int inst, input logic [7:0] d, input logic flip, input logic stop_v);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (inst == 1) bits.push_back((^d) ^ flip);
        bits.push_back(stop_v);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            if (inst == 0) rxd_drv_a = bits[i];
            else           rxd_drv_p = bits[i];
            step(BIT_CYC);
        end
    endtask

    task automatic pop(input int inst);
        if (inst == 0) rx_rd_a = 1'b1; else rx_rd_p = 1'b1;
        step(1);
        rx_rd_a = 1'b0;
        rx_rd_p = 1'b0;
    endtask

    task automatic clr(input int inst);
        if (inst == 0) err_clr_a = 1'b1; else err_clr_p = 1'b1;
        step(1);
        err_clr_a = 1'b0;
        err_clr_p = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd_a); end
        checks++; if (tx_full_a !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b want 0", tx_full_a); end
        checks++; if (tx_idle_a !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b want 1", tx_idle_a); end
        checks++; if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty_a); end
        checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data_a); end
        checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", err_a); end
        checks++; if (rx_empty_p !== 1'b1) begin errors++; $display("FAIL reset_rx_empty_p: got %b want 1", rx_empty_p); end
        checks++; if (err_p !== 4'b0000) begin errors++; $display("FAIL reset_err_p: got %b want 0000", err_p); end
    endtask

    task automatic test_tx_8n1();
        logic [7:0] d;
        logic       exp_bits[$];
        bit         seen;
        d = 8'hA5;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(1'b1);
        tx_data_a = d; tx_wr_a = 1'b1; step(1); tx_wr_a = 1'b0;
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin if (txd_a === 1'b0) seen = 1; else step(1); end
        checks++; if (!seen) begin errors++; $display("FAIL tx_start: txd got 1 want falling edge within 200 cycles"); end
        step(BIT_CYC / 2);
        foreach (exp_bits[i]) begin
            checks++;
            if (txd_a !== exp_bits[i]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", i, txd_a, exp_bits[i]); end
            step(BIT_CYC);
        end
        checks++; if (tx_idle_a !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b want 1", tx_idle_a); end
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL tx_line_idle: got %b want 1", txd_a); end
    endtask

    task automatic test_loopback();
        logic [7:0] q[$];
        bit         seen;
        loop_en = 1'b1;
        q = '{8'h00, 8'hFF, 8'h3C};
        foreach (q[i]) begin tx_data_a = q[i]; tx_wr_a = 1'b1; step(1); end
        tx_wr_a = 1'b0;
        seen = 0;
        for (int t = 0; t < 5000 && !seen; t++) begin if (tx_idle_a === 1'b1) seen = 1; else step(1); end
        checks++; if (!seen) begin errors++; $display("FAIL loop_tx_done: tx_idle got 0 want 1 within 5000 cycles"); end
        step(BIT_CYC);
        foreach (q[i]) begin
            checks++; if (rx_empty_a !== 1'b0) begin errors++; $display("FAIL loop_avail%0d: rx_empty got %b want 0", i, rx_empty_a); end
            checks++; if (rx_data_a !== q[i]) begin errors++; $display("FAIL loop_data%0d: got %h want %h", i, rx_data_a, q[i]); end
            pop(0);
        end
        checks++; if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL loop_drained: rx_empty got %b want 1", rx_empty_a); end
        checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL loop_err: got %b want 0000", err_a); end
        loop_en = 1'b0;
    endtask

    task automatic test_parity();
        send_frame(1, 8'h07, 1'b1, 1'b1);
        checks++; if (rx_empty_p !== 1'b0) begin errors++; $display("FAIL par_avail: rx_empty got %b want 0", rx_empty_p); end
        checks++; if (rx_data_p !== 8'h07) begin errors++; $display("FAIL par_data: got %h want 07", rx_data_p); end
        checks++; if (err_p !== 4'b0001) begin errors++; $display("FAIL par_err: got %b want 0001", err_p); end
        pop(1);
        clr(1);
        checks++; if (err_p !== 4'b0000) begin errors++; $display("FAIL par_clr: got %b want 0000", err_p); end
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h96, 1'b0, 1'b0);
        checks++; if (rx_empty_a !== 1'b0) begin errors++; $display("FAIL frm_avail: rx_empty got %b want 0", rx_empty_a); end
        checks++; if (rx_data_a !== 8'h96) begin errors++; $display("FAIL frm_data: got %h want 96", rx_data_a); end
        checks++; if (err_a !== 4'b0010) begin errors++; $display("FAIL frm_err: got %b want 0010", err_a); end
        pop(0);
        clr(0);
        checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL frm_clr: got %b want 0000", err_a); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [3:0] exp_err;
        exp_err = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            d = 8'($urandom);
            send_frame(1, d, 1'b0, 1'b1);
            if (q.size() < 4) q.push_back(d); else exp_err[2] = 1'b1;
        end
        checks++; if (err_p !== exp_err) begin errors++; $display("FAIL ovr_err: got %b want %b", err_p, exp_err); end
        foreach (q[i]) begin
            checks++; if (rx_data_p !== q[i] || rx_empty_p !== 1'b0) begin
                errors++; $display("FAIL ovr_data%0d: got %h empty %b want %h empty 0", i, rx_data_p, rx_empty_p, q[i]); end
            pop(1);
        end
        checks++; if (rx_empty_p !== 1'b1) begin errors++; $display("FAIL ovr_drained: rx_empty got %b want 1", rx_empty_p); end
        clr(1);
    endtask

    task automatic test_tx_overflow();
        logic [7:0] q[$];
        logic [7:0] d;
        bit         seen;
        loop_en = 1'b1;
        d = 8'($urandom);
        q.push_back(d);
        tx_data_a = d; tx_wr_a = 1'b1; step(1); tx_wr_a = 1'b0;
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin if (txd_a === 1'b0) seen = 1; else step(1); end
        checks++; if (!seen) begin errors++; $display("FAIL ovf_start: txd got 1 want falling edge within 200 cycles"); end
        // Transmitter is busy with the first byte, so the FIFO holds 16 and the 17th is lost
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            tx_data_a = d; tx_wr_a = 1'b1;
            if (q.size() < 17) q.push_back(d);
            step(1);
        end
        tx_wr_a = 1'b0;
        checks++; if (tx_full_a !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", tx_full_a); end
        checks++; if (err_a !== 4'b1000) begin errors++; $display("FAIL ovf_flag: got %b want 1000", err_a); end
        tx_data_a = 8'h5A; tx_wr_a = 1'b1; err_clr_a = 1'b1; step(1); tx_wr_a = 1'b0; err_clr_a = 1'b0;
        checks++; if (err_a !== 4'b1000) begin errors++; $display("FAIL ovf_beats_clr: got %b want 1000", err_a); end
        clr(0);
        checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b want 0000", err_a); end
        foreach (q[i]) begin
            seen = 0;
            for (int t = 0; t < 2000 && !seen; t++) begin if (rx_empty_a === 1'b0) seen = 1; else step(1); end
            checks++; if (!seen || rx_data_a !== q[i]) begin
                errors++; $display("FAIL ovf_rx%0d: got %h empty %b want %h empty 0", i, rx_data_a, rx_empty_a, q[i]); end
            pop(0);
        end
        step(2 * BIT_CYC);
        checks++; if (rx_empty_a !== 1'b1 || tx_idle_a !== 1'b1) begin
            errors++; $display("FAIL ovf_drained: rx_empty %b tx_idle %b want 1 1", rx_empty_a, tx_idle_a); end
        checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL ovf_rx_err: got %b want 0000", err_a); end
        loop_en = 1'b0;
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic       flip, stop_v;
        logic [3:0] exp_err;
        for (int n = 0; n < 6; n++) begin
            d       = 8'($urandom);
            flip    = 1'($urandom_range(0, 1));
            stop_v  = ($urandom_range(0, 3) != 0);
            exp_err = {2'b00, ~stop_v, flip};
            send_frame(1, d, flip, stop_v);
            checks++; if (rx_empty_p !== 1'b0 || rx_data_p !== d) begin
                errors++; $display("FAIL rnd_data%0d: got %h empty %b want %h empty 0", n, rx_data_p, rx_empty_p, d); end
            checks++; if (err_p !== exp_err) begin errors++; $display("FAIL rnd_err%0d: got %b want %b", n, err_p, exp_err); end
            pop(1);
            clr(1);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int lows;
        for (int i = 0; i < 3; i++) begin tx_data_a = 8'(8'h11 * (i + 1)); tx_wr_a = 1'b1; step(1); end
        tx_wr_a = 1'b0;
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin if (txd_a === 1'b0) seen = 1; else step(1); end
        checks++; if (!seen) begin errors++; $display("FAIL rst_start: txd got 1 want falling edge within 200 cycles"); end
        rxd_drv_p = 1'b0;
        step(BIT_CYC + BIT_CYC / 2);
        checks++; if (tx_idle_a !== 1'b0) begin errors++; $display("FAIL rst_busy: tx_idle got %b want 0", tx_idle_a); end
        reset = 1'b1;
        step(1);
        rxd_drv_p = 1'b1;
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b want 1", txd_a); end
        checks++; if (tx_idle_a !== 1'b1 || tx_full_a !== 1'b0) begin
            errors++; $display("FAIL rst_tx_fifo: idle %b full %b want 1 0", tx_idle_a, tx_full_a); end
        step(2);
        reset = 1'b0;
        lows = 0;
        for (int t = 0; t < 1200; t++) begin if (txd_a !== 1'b1) lows++; step(1); end
        checks++; if (lows != 0) begin errors++; $display("FAIL rst_tx_quiet: low cycles got %0d want 0", lows); end
        checks++; if (rx_empty_p !== 1'b1 || err_p !== 4'b0000) begin
            errors++; $display("FAIL rst_rx_discard: empty %b err %b want 1 0000", rx_empty_p, err_p); end
    endtask

    task automatic test_glitch();
        rxd_drv_a = 1'b0;
        step(4);
        rxd_drv_a = 1'b1;
        step(12 * BIT_CYC);
        checks++; if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL glitch_push: rx_empty got %b want 1", rx_empty_a); end
        checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL glitch_err: got %b want 0000", err_a); end
    endtask

    initial begin
        reset = 1'b1; loop_en = 1'b0;
        rxd_drv_a = 1'b1; tx_wr_a = 1'b0; tx_data_a = '0; rx_rd_a = 1'b0; err_clr_a = 1'b0;
        rxd_drv_p = 1'b1; tx_wr_p = 1'b0; tx_data_p = '0; rx_rd_p = 1'b0; err_clr_p = 1'b0;
        step(5);
        reset = 1'b0;
        step(2);
        test_reset();
        test_tx_8n1();
        test_loopback();
        test_parity();
        test_frame_err();
        test_rx_overrun();
        test_tx_overflow();
        test_random_frames();
        test_reset_mid();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
